// File: rtl/float_to_int_serial.sv
// Serial converter from the 31-bit unsigned float format {exp[7:0], man[22:0]} to a
// non-negative 32-bit integer, using a one-bit-per-cycle shifter behind valid/ready.
module float_to_int_serial #(
    parameter int unsigned BIAS = 127
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [30:0] i_float,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_int,
    output logic        o_sat
);

    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MAN_W   = 23;
    localparam int unsigned INT_W   = 32;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned E_UNITY = BIAS + MAN_W;
    localparam int unsigned E_MAX   = BIAS + 30;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, state_nx;
    logic [INT_W-1:0]   shreg, shreg_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               dir_left, dir_left_nx;
    logic               sat_r, sat_nx;
    logic               o_valid_nx;
    logic [INT_W-1:0]   o_int_nx;
    logic               o_sat_nx;

    logic               accept_c;
    logic [31:0]        exp_c;
    logic [INT_W-1:0]   sig_c;

    assign o_ready  = (state == IDLE) && !i_rst;
    assign accept_c = i_valid && o_ready;
    assign exp_c    = 32'(i_float[30:MAN_W]);
    assign sig_c    = INT_W'({1'b1, i_float[MAN_W-1:0]});

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            dir_left <= 1'b0;
            sat_r    <= 1'b0;
            o_valid  <= 1'b0;
            o_int    <= '0;
            o_sat    <= 1'b0;
        end else begin
            state    <= state_nx;
            shreg    <= shreg_nx;
            cnt      <= cnt_nx;
            dir_left <= dir_left_nx;
            sat_r    <= sat_nx;
            o_valid  <= o_valid_nx;
            o_int    <= o_int_nx;
            o_sat    <= o_sat_nx;
        end
    end

    // Next-state and datapath; special cases park their result in shreg directly
    always_comb begin
        state_nx    = state;
        shreg_nx    = shreg;
        cnt_nx      = cnt;
        dir_left_nx = dir_left;
        sat_nx      = sat_r;
        o_valid_nx  = o_valid;
        o_int_nx    = o_int;
        o_sat_nx    = o_sat;

        case (state)
            IDLE: begin
                if (accept_c) begin
                    sat_nx = 1'b0;
                    if (exp_c < BIAS) begin
                        shreg_nx = '0;
                        state_nx = DONE;
                    end else if (exp_c > E_MAX) begin
                        shreg_nx = 32'h7FFF_FFFF;
                        sat_nx   = 1'b1;
                        state_nx = DONE;
                    end else if (exp_c == E_UNITY) begin
                        shreg_nx = sig_c;
                        state_nx = DONE;
                    end else if (exp_c > E_UNITY) begin
                        shreg_nx    = sig_c;
                        dir_left_nx = 1'b1;
                        cnt_nx      = CNT_W'(exp_c - E_UNITY);
                        state_nx    = SHIFT;
                    end else begin
                        shreg_nx    = sig_c;
                        dir_left_nx = 1'b0;
                        cnt_nx      = CNT_W'(E_UNITY - exp_c);
                        state_nx    = SHIFT;
                    end
                end
            end
            SHIFT: begin
                shreg_nx = dir_left ? (shreg << 1) : (shreg >> 1);
                cnt_nx   = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                // First DONE cycle publishes the result; it then holds until consumed
                if (!o_valid) begin
                    o_valid_nx = 1'b1;
                    o_int_nx   = shreg;
                    o_sat_nx   = sat_r;
                end else if (i_ready) begin
                    o_valid_nx = 1'b0;
                    state_nx   = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_float_to_int_serial.sv
// Directed-vector and round-trip bench for float_to_int_serial.
module tb_float_to_int_serial;

    localparam int unsigned BIAS = 127;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [30:0] i_float;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_int;
    logic        o_sat;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [30:0] f;
        logic [31:0] exp_int;
        logic        exp_sat;
        int          exp_lat;
    } vec_t;

    always #5 clk = ~clk;

    float_to_int_serial #(.BIAS(BIAS)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_float (i_float),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_int   (o_int),
        .o_sat   (o_sat)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference int-to-float encoder
    function automatic logic [30:0] to_float(input logic [31:0] v);
        int p;
        logic [22:0] man;
        p = -1;
        for (int b = 0; b < 32; b++) if (v[b]) p = b;
        if (p < 0) return 31'd0;
        if (p >= 23) man = 23'(v >> (p - 23));
        else         man = 23'(v << (23 - p));
        return {8'(BIAS + 32'(p)), man};
    endfunction

    // One full transaction: accept, wait for result, optional stall, handshake
    task automatic convert(input logic [30:0] f, input int exp_lat, input logic [31:0] exp_int,
                           input logic exp_sat, input int stall, input string tag);
        int n;
        check({tag, " ready"}, 32'(o_ready), 32'd1);
        i_valid = 1'b1;
        i_float = f;
        tick();
        i_valid = 1'b0;
        i_float = 31'($urandom);
        n = 0;
        while (!o_valid && n < 40) begin
            tick();
            n++;
        end
        if (!o_valid) begin
            check({tag, " timeout"}, 32'(o_valid), 32'd1);
            return;
        end
        if (exp_lat >= 0) check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " int"}, o_int, exp_int);
        check({tag, " sat"}, 32'(o_sat), 32'(exp_sat));
        for (int s = 0; s < stall; s++) begin
            tick();
            check({tag, " stall valid"}, 32'(o_valid), 32'd1);
            check({tag, " stall int"}, o_int, exp_int);
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check({tag, " valid drop"}, 32'(o_valid), 32'd0);
        check({tag, " ready back"}, 32'(o_ready), 32'd1);
    endtask

    initial begin
        vec_t vecs[15];
        logic [31:0] v;
        logic [31:0] exp_v;
        int p;
        int k;

        vecs[0]  = '{31'h3F800000, 32'd1,          1'b0, 24};
        vecs[1]  = '{31'h4B000005, 32'd8388613,    1'b0, 1};
        vecs[2]  = '{31'h4EFFFFFF, 32'h7FFFFF80,   1'b0, 8};
        vecs[3]  = '{31'h4F000000, 32'h7FFFFFFF,   1'b1, 1};
        vecs[4]  = '{31'h7F800000, 32'h7FFFFFFF,   1'b1, 1};
        vecs[5]  = '{31'h32000000, 32'd0,          1'b0, 1};
        vecs[6]  = '{31'h00000000, 32'd0,          1'b0, 1};
        vecs[7]  = '{31'h40000000, 32'd2,          1'b0, 23};
        vecs[8]  = '{31'h40400000, 32'd3,          1'b0, 23};
        vecs[9]  = '{31'h3FFFFFFF, 32'd1,          1'b0, 24};
        vecs[10] = '{31'h4B7FFFFF, 32'h00FFFFFF,   1'b0, 1};
        vecs[11] = '{31'h4B800000, 32'h01000000,   1'b0, 2};
        vecs[12] = '{31'h3F7FFFFF, 32'd0,          1'b0, 1};
        vecs[13] = '{31'h4E800001, 32'h40000080,   1'b0, 8};
        vecs[14] = '{31'h47000000, 32'h00008000,   1'b0, 9};

        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_float = '0;
        tick();
        tick();
        check("reset valid", 32'(o_valid), 32'd0);
        check("reset int", o_int, 32'd0);
        check("reset sat", 32'(o_sat), 32'd0);
        check("reset ready low", 32'(o_ready), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 15; i++) begin
            convert(vecs[i].f, vecs[i].exp_lat, vecs[i].exp_int, vecs[i].exp_sat, i % 3,
                    $sformatf("vec%0d", i));
        end

        // Backpressure: result held, extra inputs dropped
        i_valid = 1'b1;
        i_float = 31'h4B000005;
        tick();
        i_valid = 1'b0;
        tick();
        check("bp valid", 32'(o_valid), 32'd1);
        for (int s = 0; s < 5; s++) begin
            i_valid = s[0];
            i_float = 31'h4F000000;
            tick();
            check("bp hold valid", 32'(o_valid), 32'd1);
            check("bp hold int", o_int, 32'd8388613);
            check("bp hold sat", 32'(o_sat), 32'd0);
            check("bp ready low", 32'(o_ready), 32'd0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("bp idle valid", 32'(o_valid), 32'd0);
        check("bp idle ready", 32'(o_ready), 32'd1);
        for (int s = 0; s < 3; s++) begin
            tick();
            check("bp nothing queued", 32'(o_valid), 32'd0);
        end

        // Reset in the middle of a long right shift
        i_valid = 1'b1;
        i_float = 31'h3F800000;
        tick();
        i_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("rst mid valid", 32'(o_valid), 32'd0);
        check("rst mid int", o_int, 32'd0);
        check("rst mid sat", 32'(o_sat), 32'd0);
        check("rst mid ready low", 32'(o_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rst mid ready", 32'(o_ready), 32'd1);
        convert(31'h4B000005, 1, 32'd8388613, 1'b0, 0, "post rst");

        // Round trip through the reference encoder with random stalls
        for (int i = 0; i < 2000; i++) begin
            v = 32'($urandom) & 32'h7FFFFFFF;
            p = $urandom_range(30, 0);
            v = (v >> (30 - p)) | (32'd1 << p);
            if (i % 97 == 0) v = 32'd0;
            if (v == 32'd0) begin
                exp_v = 32'd0;
                k = 0;
            end else if (p > 23) begin
                exp_v = (v >> (p - 23)) << (p - 23);
                k = p - 23;
            end else begin
                exp_v = v;
                k = 23 - p;
            end
            convert(to_float(v), k + 1, exp_v, 1'b0,
                    ($urandom_range(3, 0) == 0) ? $urandom_range(3, 1) : 0, "rt");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
